seg_to_binary: RTL

SEG_TO_BINARY -- requirements
Module: seg_to_binary

---
 rtl/seg_to_binary_if.sv | 30 +++
 rtl/seg_to_binary.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg_to_binary_if.sv
// seg_to_binary_if -- handshake bundle for the seven-segment to binary decoder.
//   seg_in[6:0]  {a,b,c,d,e,f,g}, active-low segments
//   seg_valid    seg_in is valid this cycle
//   seg_ready    decoder accepts a digit this cycle
//   clear        synchronous abort back to IDLE
//   bin_out[3:0] decoded value 0..15
//   bin_valid    bin_out is valid
//   bin_ready    consumer takes bin_out
//   err          decode/range error latched
// master = digit producer / result consumer, slave = decoder.
interface seg_to_binary_if;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       seg_ready;
    logic       clear;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       bin_ready;
    logic       err;

    modport master (
        output seg_in, seg_valid, clear, bin_ready,
        input  seg_ready, bin_out, bin_valid, err
    );

    modport slave (
        input  seg_in, seg_valid, clear, bin_ready,
        output seg_ready, bin_out, bin_valid, err
    );
endinterface

// File: rtl/seg_to_binary.sv
// seg_to_binary -- takes two seven-segment digits (tens then ones) and
// produces their binary value 0..15, flagging anything else as an error.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seg_to_binary_if.slave (digit in, binary out, clear, err)
// Optional macro SEG_TIMEOUT_EN: abandon a held tens digit after
// TIMEOUT_CYCLES cycles in TENS with no ones digit, returning to IDLE.
module seg_to_binary #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_to_binary_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_TENS, S_OUT, S_ERR} state_e;

    state_e     state_q, state_d;
    logic       tens_q, tens_d;
    logic [3:0] bin_q, bin_d;

    // Pattern decode; is_digit only for the ten table entries.
    logic [3:0] digit;
    logic       is_digit;
    logic       is_blank;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (bus.seg_in)
            7'b0000001: digit = 4'd0;
            7'b1001111: digit = 4'd1;
            7'b0010010: digit = 4'd2;
            7'b0000110: digit = 4'd3;
            7'b1001100: digit = 4'd4;
            7'b0100100: digit = 4'd5;
            7'b0100000: digit = 4'd6;
            7'b0001111: digit = 4'd7;
            7'b0000000: digit = 4'd8;
            7'b0001100: digit = 4'd9;
            default:    is_digit = 1'b0;
        endcase
        is_blank = (bus.seg_in == 7'b1111111);
    end

    // 5-bit sum so that e.g. 19 is caught by the range check instead of wrapping.
    logic [4:0] sum;
    assign sum = (tens_q ? 5'd10 : 5'd0) + {1'b0, digit};

`ifdef SEG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Counts idle TENS cycles; zero whenever TENS is (re)entered or left.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_TENS && state_d == S_TENS && !bus.seg_valid)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tens_q  <= 1'b0;
            bin_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            bin_q   <= bin_d;
        end
    end

    // Next state. seg_ready is 1 in IDLE/TENS, so seg_valid there is an accept.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        bin_d   = bin_q;
        case (state_q)
            S_IDLE: begin
                if (bus.seg_valid) begin
                    if (is_blank || (is_digit && digit == 4'd0)) begin
                        tens_d  = 1'b0;
                        state_d = S_TENS;
                    end else if (is_digit && digit == 4'd1) begin
                        tens_d  = 1'b1;
                        state_d = S_TENS;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_TENS: begin
                if (bus.seg_valid) begin
                    if (is_digit && sum <= 5'd15) begin
                        bin_d   = sum[3:0];
                        state_d = S_OUT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
`ifdef SEG_TIMEOUT_EN
                else if (timeout) begin
                    tens_d  = 1'b0;
                    state_d = S_IDLE;
                end
`endif
            end
            S_OUT: begin
                if (bus.bin_ready) state_d = S_IDLE;
            end
            S_ERR: state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        // clear beats any simultaneous accept or handshake; bin_out is kept.
        if (bus.clear) begin
            state_d = S_IDLE;
            tens_d  = 1'b0;
            bin_d   = bin_q;
        end
    end

    // Outputs
    always_comb begin
        bus.seg_ready = (state_q == S_IDLE) || (state_q == S_TENS);
        bus.bin_valid = (state_q == S_OUT);
        bus.err       = (state_q == S_ERR);
        bus.bin_out   = bin_q;
    end

endmodule
